// File: rtl/proc_display.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : proc_display
//  Purpose  : 4-digit multiplexed common-anode 7-segment output stage for the
//             accumulator processor. The 8-bit value is shown as 3 decimal
//             digits, converted with a sequential double-dabble engine. The
//             leftmost digit shows the controller state code, or 'H' when
//             the processor is halted.
//  Options  : DISP_LZB_EN - leading-zero blanking of the hundreds/tens digits
//  Revision : 1.0 - initial release
// ============================================================================
module proc_display #(
    parameter int REFRESH_BITS = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] value,
    input  logic [3:0] state,
    input  logic       halt,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       busy
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_load   = 2'd1;
    localparam logic [1:0] c_st_shift  = 2'd2;
    localparam logic [1:0] c_st_commit = 2'd3;

    localparam logic [6:0] c_glyph_h     = 7'b0001001;
    localparam logic [6:0] c_glyph_blank = 7'b1111111;

    localparam logic [REFRESH_BITS-1:0] c_scan_one = {{(REFRESH_BITS-1){1'b0}}, 1'b1};

    logic [1:0]              r_fsm;
    logic [7:0]              r_cap;
    logic [7:0]              r_shown_bin;
    logic [19:0]             r_shreg;
    logic [2:0]              r_iter;
    logic [3:0]              r_hund;
    logic [3:0]              r_tens;
    logic [3:0]              r_units;
    logic                    r_busy;
    logic [REFRESH_BITS-1:0] r_scan;
    logic [3:0]              r_an;
    logic [6:0]              r_seg;
    logic                    r_dp;

    logic [19:0]             w_adj;
    logic [1:0]              w_sel;
    logic [6:0]              w_seg_next;

    // Hex digit to active-low {g,f,e,d,c,b,a} segment pattern
    function automatic logic [6:0] f_hex_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    // Binary bits pass through untouched; each BCD nibble gets +3 when >= 5
    // so that the following left shift carries correctly into the next digit.
    assign w_adj[7:0] = r_shreg[7:0];
    for (genvar gi = 0; gi < 3; gi++) begin : g_adj
        assign w_adj[8+4*gi +: 4] = (r_shreg[8+4*gi +: 4] >= 4'd5)
                                  ? (r_shreg[8+4*gi +: 4] + 4'd3)
                                  : r_shreg[8+4*gi +: 4];
    end

    assign w_sel = r_scan[REFRESH_BITS-1:REFRESH_BITS-2];

    // Pick the glyph for the digit slot selected by the scan counter
    always_comb begin
        w_seg_next = c_glyph_blank;
        case (w_sel)
            2'd0:    w_seg_next = f_hex_glyph(r_units);
            2'd1:    w_seg_next = f_hex_glyph(r_tens);
            2'd2:    w_seg_next = f_hex_glyph(r_hund);
            default: w_seg_next = halt ? c_glyph_h : f_hex_glyph(state);
        endcase
`ifdef DISP_LZB_EN
        if ((w_sel == 2'd2) && (r_hund == 4'd0)) begin
            w_seg_next = c_glyph_blank;
        end
        if ((w_sel == 2'd1) && (r_hund == 4'd0) && (r_tens == 4'd0)) begin
            w_seg_next = c_glyph_blank;
        end
`endif
    end

    // Conversion FSM: capture on mismatch, 8 adjust-and-shift steps, commit
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fsm       <= c_st_idle;
            r_cap       <= 8'd0;
            r_shown_bin <= 8'd0;
            r_shreg     <= 20'd0;
            r_iter      <= 3'd0;
            r_hund      <= 4'd0;
            r_tens      <= 4'd0;
            r_units     <= 4'd0;
            r_busy      <= 1'b0;
        end else begin
            case (r_fsm)
                c_st_idle: begin
                    if (value != r_shown_bin) begin
                        r_cap  <= value;
                        r_busy <= 1'b1;
                        r_fsm  <= c_st_load;
                    end
                end
                c_st_load: begin
                    r_shreg <= {12'd0, r_cap};
                    r_iter  <= 3'd0;
                    r_fsm   <= c_st_shift;
                end
                c_st_shift: begin
                    r_shreg <= {w_adj[18:0], 1'b0};
                    r_iter  <= r_iter + 3'd1;
                    if (r_iter == 3'd7) begin
                        r_fsm <= c_st_commit;
                    end
                end
                default: begin
                    r_hund      <= r_shreg[19:16];
                    r_tens      <= r_shreg[15:12];
                    r_units     <= r_shreg[11:8];
                    r_shown_bin <= r_cap;
                    r_busy      <= 1'b0;
                    r_fsm       <= c_st_idle;
                end
            endcase
        end
    end

    // Free-running scan counter and registered digit drive (one clock behind sel)
    always_ff @(posedge clock) begin
        if (reset) begin
            r_scan <= '0;
            r_an   <= 4'b1111;
            r_seg  <= c_glyph_blank;
            r_dp   <= 1'b1;
        end else begin
            r_scan <= r_scan + c_scan_one;
            r_an   <= ~(4'b0001 << w_sel);
            r_seg  <= w_seg_next;
            r_dp   <= ~((w_sel == 2'd0) && r_busy);
        end
    end

    assign an   = r_an;
    assign seg  = r_seg;
    assign dp   = r_dp;
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_proc_display.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_proc_display
//  Purpose  : Self-checking bench for proc_display (REFRESH_BITS=4). A
//             transaction-level model predicts displayed value, busy window
//             and scan slot each clock; directed slot checks cover the
//             documented glyph scenarios, followed by random traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_proc_display;

    logic       clock;
    logic       reset;
    logic [7:0] value;
    logic [3:0] state;
    logic       halt;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       busy;

    int tests_run = 0;
    int tests_failed = 0;

    // Model: the value currently on display, and an in-flight conversion
    int         m_shown;
    int         m_cap;
    bit         m_busy;
    int         m_left;
    logic [3:0] m_scan;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic       exp_busy;

    logic [6:0] glyph_tbl [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    proc_display #(.REFRESH_BITS(4)) u_dut (
        .clock (clock),
        .reset (reset),
        .value (value),
        .state (state),
        .halt  (halt),
        .an    (an),
        .seg   (seg),
        .dp    (dp),
        .busy  (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected glyph for a slot, derived from the decimal value on display
    function automatic logic [6:0] model_glyph(input int sel, input int shown,
                                               input logic h, input logic [3:0] st);
        int hd, td, ud;
        hd = shown / 100;
        td = (shown / 10) % 10;
        ud = shown % 10;
        case (sel)
            0: return glyph_tbl[ud];
`ifdef DISP_LZB_EN
            1: return (hd == 0 && td == 0) ? 7'b1111111 : glyph_tbl[td];
            2: return (hd == 0) ? 7'b1111111 : glyph_tbl[hd];
`else
            1: return glyph_tbl[td];
            2: return glyph_tbl[hd];
`endif
            default: return h ? 7'b0001001 : glyph_tbl[st];
        endcase
    endfunction

    // One clock: advance the model with the inputs present at the edge, then check
    task automatic step();
        int sel;
        @(posedge clock);
        if (reset) begin
            m_scan = 4'd0;
            m_shown = 0;
            m_busy = 0;
            m_left = 0;
            exp_an = 4'b1111;
            exp_seg = 7'b1111111;
            exp_dp = 1'b1;
        end else begin
            sel = int'(m_scan[3:2]);
            exp_an = ~(4'b0001 << sel);
            exp_seg = model_glyph(sel, m_shown, halt, state);
            exp_dp = !(sel == 0 && m_busy);
            m_scan = m_scan + 4'd1;
            if (!m_busy) begin
                if (int'(value) != m_shown) begin
                    m_busy = 1;
                    m_cap = int'(value);
                    m_left = 10;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_shown = m_cap;
                    m_busy = 0;
                end
            end
        end
        exp_busy = m_busy;
        #1;
        check_val("an", an, exp_an);
        check_val("seg", seg, exp_seg);
        check_val("dp", dp, exp_dp);
        check_val("busy", busy, exp_busy);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Step until the given digit slot is driven, then check its glyph
    task automatic slot_check(input string tag, input logic [3:0] slot, input logic [6:0] glyph);
        int k;
        k = 0;
        while (an !== slot && k < 20) begin
            step();
            k++;
        end
        if (an !== slot) check_val({tag, "_timeout"}, an, slot);
        else check_val(tag, seg, glyph);
    endtask

    initial begin
        reset = 1'b1;
        value = 8'd0;
        state = 4'd0;
        halt  = 1'b0;
        m_scan = 4'd0;
        m_shown = 0;
        m_cap = 0;
        m_busy = 0;
        m_left = 0;

        // Reset, then idle scan with value 0
        run(2);
        check_val("rst_an", an, 4'b1111);
        check_val("rst_seg", seg, 7'b1111111);
        reset = 1'b0;
        run(20);
`ifndef DISP_LZB_EN
        slot_check("zero_hund", 4'b1011, 7'b1000000);
`endif
        slot_check("zero_units", 4'b1110, 7'b1000000);

        // 255 -> 2,5,5
        value = 8'd255;
        run(16);
        slot_check("v255_hund", 4'b1011, 7'b0100100);
        slot_check("v255_tens", 4'b1101, 7'b0010010);
        slot_check("v255_units", 4'b1110, 7'b0010010);

        // 7, with or without leading-zero blanking
        value = 8'd7;
        run(16);
`ifdef DISP_LZB_EN
        slot_check("v7_hund", 4'b1011, 7'b1111111);
        slot_check("v7_tens", 4'b1101, 7'b1111111);
`else
        slot_check("v7_hund", 4'b1011, 7'b1000000);
        slot_check("v7_tens", 4'b1101, 7'b1000000);
`endif
        slot_check("v7_units", 4'b1110, 7'b1111000);

        // Status digit: state code, then halt
        state = 4'hA;
        slot_check("state_a", 4'b0111, 7'b0001000);
        halt = 1'b1;
        run(2);
        slot_check("halt_h", 4'b0111, 7'b0001001);
        halt = 1'b0;

        // 100 then 42 arriving mid-conversion
        value = 8'd100;
        run(4);
        value = 8'd42;
        run(30);
        slot_check("v42_units", 4'b1110, 7'b0100100);

        // Reset mid-conversion of 200, then restart
        value = 8'd200;
        run(5);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        run(14);
        slot_check("v200_hund", 4'b1011, 7'b0100100);

        // Random traffic
        for (int r = 0; r < 40; r++) begin
            value = 8'($urandom_range(0, 255));
            state = 4'($urandom_range(0, 15));
            halt  = 1'($urandom_range(0, 1));
            run(int'($urandom_range(1, 25)));
        end
        run(12);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
